// File: rtl/sequenciador_contador_pkg.sv
// Shared state codes and widths for the counter sequencer.
package sequenciador_contador_pkg;

    localparam int unsigned W_ESTADO = 4;
    localparam int unsigned W_DADO   = 4;

    // Codes are visible on db_estado, so their values are fixed.
    typedef enum logic [W_ESTADO-1:0] {
        INICIAL     = 4'd0,
        ZERA        = 4'd1,
        CARREGA     = 4'd2,
        CONTA       = 4'd3,
        PAUSA       = 4'd4,
        ESPERA_MEIO = 4'd5,
        FIM         = 4'd15
    } estado_t;

endpackage

// File: rtl/sequenciador_contador_voltas.sv
// Lap register: counts rco laps and flags the final one.
module contador_voltas #(
    parameter int unsigned NUM_VOLTAS = 1,
    parameter int unsigned W_VOLTAS   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic incrementa,
    output logic ultima
);

    logic [W_VOLTAS-1:0] volta_q;
    logic [W_VOLTAS-1:0] volta_d;

    // Next lap value: clear has priority over increment.
    always_comb begin
        volta_d = volta_q;
        if (limpa) begin
            volta_d = '0;
        end else if (incrementa) begin
            volta_d = volta_q + W_VOLTAS'(1);
        end
    end

    // Lap register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            volta_q <= '0;
        end else begin
            volta_q <= volta_d;
        end
    end

    assign ultima = (volta_q == W_VOLTAS'(NUM_VOLTAS - 1));

endmodule

// File: rtl/sequenciador_contador.sv
// Moore sequencer driving a 163-style 4-bit counter: clear, load, count laps, done pulse.
// Optional mid-count stop at Q=8 enabled by SEQ_CONTADOR_PAUSA_MEIO_EN.
module sequenciador_contador
    import sequenciador_contador_pkg::*;
#(
    parameter int unsigned NUM_VOLTAS = 1,
    parameter int unsigned W_VOLTAS   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              pausar,
    input  logic              continuar,
    input  logic [W_DADO-1:0] valor_inicial,
    input  logic              rco,
    input  logic              meio,
    output logic              zera_n,
    output logic              carrega_n,
    output logic              conta,
    output logic [W_DADO-1:0] D,
    output logic              ocupado,
    output logic              pronto,
    output logic [W_ESTADO-1:0] db_estado
);

    estado_t             estado_q, estado_d;
    logic [W_DADO-1:0]   d_q, d_d;
    logic                zera_n_q, zera_n_d;
    logic                carrega_n_q, carrega_n_d;
    logic                conta_q, conta_d;
    logic                ocupado_q, ocupado_d;
    logic                pronto_q, pronto_d;
    logic                limpa_volta;
    logic                inc_volta;
    logic                ultima;

    contador_voltas #(
        .NUM_VOLTAS (NUM_VOLTAS),
        .W_VOLTAS   (W_VOLTAS)
    ) u_voltas (
        .clock      (clock),
        .reset      (reset),
        .limpa      (limpa_volta),
        .incrementa (inc_volta),
        .ultima     (ultima)
    );

`ifndef SEQ_CONTADOR_PAUSA_MEIO_EN
    logic unused_c;
    assign unused_c = ^{meio, continuar};
`endif

    // Next state, lap control and Moore outputs decoded from the next state.
    always_comb begin
        estado_d    = estado_q;
        d_d         = d_q;
        limpa_volta = 1'b0;
        inc_volta   = 1'b0;
        case (estado_q)
            INICIAL: begin
                if (iniciar) begin
                    estado_d    = ZERA;
                    d_d         = valor_inicial;
                    limpa_volta = 1'b1;
                end
            end
            ZERA:    estado_d = CARREGA;
            CARREGA: estado_d = CONTA;
            CONTA: begin
                // A terminal count is always booked before any pause request.
                if (rco) begin
                    if (ultima) begin
                        estado_d = FIM;
                    end else begin
                        inc_volta = 1'b1;
                        if (pausar) begin
                            estado_d = PAUSA;
                        end
                    end
`ifdef SEQ_CONTADOR_PAUSA_MEIO_EN
                end else if (meio) begin
                    estado_d = ESPERA_MEIO;
`endif
                end else if (pausar) begin
                    estado_d = PAUSA;
                end
            end
            PAUSA: begin
                if (!pausar) begin
                    estado_d = CONTA;
                end
            end
`ifdef SEQ_CONTADOR_PAUSA_MEIO_EN
            ESPERA_MEIO: begin
                if (continuar) begin
                    estado_d = CONTA;
                end
            end
`endif
            FIM:     estado_d = INICIAL;
            default: estado_d = INICIAL;
        endcase

        zera_n_d    = (estado_d != ZERA);
        carrega_n_d = (estado_d != CARREGA);
        conta_d     = (estado_d == CONTA);
        ocupado_d   = (estado_d != INICIAL);
        pronto_d    = (estado_d == FIM);
    end

    // State, latched start value and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= INICIAL;
            d_q         <= '0;
            zera_n_q    <= 1'b1;
            carrega_n_q <= 1'b1;
            conta_q     <= 1'b0;
            ocupado_q   <= 1'b0;
            pronto_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            d_q         <= d_d;
            zera_n_q    <= zera_n_d;
            carrega_n_q <= carrega_n_d;
            conta_q     <= conta_d;
            ocupado_q   <= ocupado_d;
            pronto_q    <= pronto_d;
        end
    end

    assign zera_n    = zera_n_q;
    assign carrega_n = carrega_n_q;
    assign conta     = conta_q;
    assign D         = d_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = W_ESTADO'(estado_q);

endmodule
